// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO with a registered head output, so the consumer sees
// the next entry in the cycle right after a pop.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when a pop frees a slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_next;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head register tracks whichever entry becomes the new head.
    if (do_push && (empty || (do_pop && count_q == CNT_W'(1)))) begin
      rdata_d = wdata;
    end else if (do_pop && count_q > CNT_W'(1)) begin
      rdata_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: line synchroniser, mid-bit sampling FSM, and a byte FIFO
// with valid/ready read side plus single-cycle framing-error/overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WAIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rx,
  output logic [UART_DATA_W-1:0] r_data,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int CNT_W = $clog2(WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WAIT / 2 - 1);

  logic                   sync1_q, rx_s_q;
  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   stop_ok_q, stop_ok_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   push_req, pop, fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          stop_ok_d = rx_s_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Frame result is acted on one edge after the stop-bit sample.
  assign push_req    = done_q && stop_ok_q;
  assign pop         = r_valid && r_ready;
  assign frame_err_d = done_q && !stop_ok_q;
  assign overrun_d   = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  rx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (r_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign r_valid   = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
